// File: rtl/alu_wb_arbiter8.sv
// alu_wb_arbiter8
// Round-robin arbiter that shares the ALU's 8:1 32-bit result mux among eight
// requesters. Each cycle it picks one requesting source, drives the mux select,
// and captures the selected word into a single-entry output stage. The output
// stage hands words to writeback with a valid/ready handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   req[7:0]   per-requester request, bit i selects mux input i
//   d0..d7     32-bit requester data
//   gnt[7:0]   one-hot combinational grant (capture happens at this edge)
//   sel[2:0]   combinational mux select (winning index, 0 when idle)
//   out[31:0]  registered result word
//   out_valid  out holds an undelivered word
//   out_ready  writeback accepts out when out_valid & out_ready

// Mux8to1x32
// Plain 8:1 32-bit result mux shared by the ALU functional units.
// Ports: sel_i (select), d0_i..d7_i (inputs), y_o (selected word).
module Mux8to1x32 (
  input  logic [2:0]  sel_i,
  input  logic [31:0] d0_i,
  input  logic [31:0] d1_i,
  input  logic [31:0] d2_i,
  input  logic [31:0] d3_i,
  input  logic [31:0] d4_i,
  input  logic [31:0] d5_i,
  input  logic [31:0] d6_i,
  input  logic [31:0] d7_i,
  output logic [31:0] y_o
);

  // Straight decode of the select onto the eight data inputs.
  always_comb begin
    y_o = d0_i;
    case (sel_i)
      3'd0: y_o = d0_i;
      3'd1: y_o = d1_i;
      3'd2: y_o = d2_i;
      3'd3: y_o = d3_i;
      3'd4: y_o = d4_i;
      3'd5: y_o = d5_i;
      3'd6: y_o = d6_i;
      3'd7: y_o = d7_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

module alu_wb_arbiter8 #(
  parameter logic [2:0] RESET_PTR = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  req,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  input  logic [31:0] d3,
  input  logic [31:0] d4,
  input  logic [31:0] d5,
  input  logic [31:0] d6,
  input  logic [31:0] d7,
  output logic [7:0]  gnt,
  output logic [2:0]  sel,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready
);

  logic [2:0]  ptr_q, ptr_d;
  logic [31:0] outData_q, outData_d;
  logic        outValid_q, outValid_d;

  logic [2:0]  winner;
  logic [2:0]  scanIdx;
  logic        found;
  logic        loadEn;
  logic        grantEn;
  logic [31:0] muxOut;

  // Round-robin scan: start one past the last granted index and take the
  // first requester found. The 3-bit add wraps, so ptr = 7 scans 0 first.
  // The winner defaults to 0, which is also the select value when idle.
  always_comb begin
    winner  = 3'd0;
    scanIdx = 3'd0;
    found   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      scanIdx = ptr_q + 3'(k);
      if (!found && req[scanIdx]) begin
        winner = scanIdx;
        found  = 1'b1;
      end
    end
  end

  // A new word may enter whenever the stage is empty or being drained on the
  // same edge; this lets a load and a drain overlap with no bubble.
  assign loadEn  = !outValid_q | out_ready;
  assign grantEn = loadEn & (req != 8'd0);
  assign sel     = winner;
  assign gnt     = grantEn ? (8'b1 << winner) : 8'd0;

  Mux8to1x32 uResultMux (
    .sel_i (sel),
    .d0_i  (d0),
    .d1_i  (d1),
    .d2_i  (d2),
    .d3_i  (d3),
    .d4_i  (d4),
    .d5_i  (d5),
    .d6_i  (d6),
    .d7_i  (d7),
    .y_o   (muxOut)
  );

  // Next-state for the output stage and priority pointer. The pointer only
  // moves on a grant, so stalled cycles do not rotate priority.
  always_comb begin
    ptr_d      = ptr_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    if (grantEn) begin
      outData_d  = muxOut;
      outValid_d = 1'b1;
      ptr_d      = winner;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending word and restores priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= RESET_PTR;
      outData_q  <= 32'h0;
      outValid_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
    end
  end

  assign out       = outData_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_alu_wb_arbiter8.sv
// tb_alu_wb_arbiter8
// Directed bench for alu_wb_arbiter8: reset priority walk, single requester,
// backpressure, wrap-around, request drop while stalled and async reset.
module tb_alu_wb_arbiter8;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;

  int checkCount;
  int failCount;

  alu_wb_arbiter8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .d4        (d4),
    .d5        (d5),
    .d6        (d6),
    .d7        (d7),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive request/ready, then let combinational outputs settle.
  task automatic applyStimulus(input logic [7:0] reqVal, input logic readyVal);
    req       = reqVal;
    out_ready = readyVal;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    req        = 8'h00;
    out_ready  = 1'b0;
    d0 = 32'hA0; d1 = 32'hA1; d2 = 32'hA2; d3 = 32'hA3;
    d4 = 32'hA4; d5 = 32'hA5; d6 = 32'hA6; d7 = 32'hA7;

    // Reset state
    #1;
    checkOutput("reset out", out, 32'h0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset gnt", {24'd0, gnt}, 32'd0);
    checkOutput("reset sel", {29'd0, sel}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset priority walk: 0..7 then 0 again
    applyStimulus(8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      checkOutput("walk gnt", {24'd0, gnt}, 32'd1 << (i % 8));
      tick();
      checkOutput("walk out", out, 32'hA0 + 32'(i % 8));
      checkOutput("walk out_valid", {31'd0, out_valid}, 32'd1);
    end

    // Single requester 5
    d5 = 32'hDEADBEEF;
    applyStimulus(8'h20, 1'b1);
    checkOutput("single gnt", {24'd0, gnt}, 32'h20);
    checkOutput("single sel", {29'd0, sel}, 32'd5);
    tick();
    checkOutput("single out", out, 32'hDEADBEEF);
    checkOutput("single out_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("idle gnt", {24'd0, gnt}, 32'd0);
    tick();
    checkOutput("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure with ptr = 1
    applyStimulus(8'h02, 1'b1);
    tick();
    checkOutput("bp preload out", out, 32'hA1);
    applyStimulus(8'h0C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp gnt", {24'd0, gnt}, 32'd0);
      checkOutput("bp sel", {29'd0, sel}, 32'd2);
      tick();
      checkOutput("bp out", out, 32'hA1);
      checkOutput("bp out_valid", {31'd0, out_valid}, 32'd1);
    end
    applyStimulus(8'h0C, 1'b1);
    checkOutput("bp release gnt", {24'd0, gnt}, 32'h04);
    tick();
    checkOutput("bp release out", out, 32'hA2);
    checkOutput("bp second gnt", {24'd0, gnt}, 32'h08);
    tick();
    checkOutput("bp second out", out, 32'hA3);

    // Wrap-around from last grant 6
    applyStimulus(8'h40, 1'b1);
    tick();
    checkOutput("wrap preload out", out, 32'hA6);
    applyStimulus(8'h81, 1'b1);
    checkOutput("wrap gnt 7", {24'd0, gnt}, 32'h80);
    tick();
    checkOutput("wrap out 7", out, 32'hA7);
    checkOutput("wrap gnt 0", {24'd0, gnt}, 32'h01);
    tick();
    checkOutput("wrap out 0", out, 32'hA0);
    checkOutput("wrap out_valid", {31'd0, out_valid}, 32'd1);

    // Drop without grant while stalled (ptr = 0, so 1 would win)
    d0 = 32'h00000B00;
    applyStimulus(8'h03, 1'b0);
    checkOutput("drop stall gnt", {24'd0, gnt}, 32'd0);
    checkOutput("drop stall sel", {29'd0, sel}, 32'd1);
    tick();
    applyStimulus(8'h01, 1'b0);
    checkOutput("drop after gnt", {24'd0, gnt}, 32'd0);
    checkOutput("drop after sel", {29'd0, sel}, 32'd0);
    tick();
    checkOutput("drop held out", out, 32'hA0);
    applyStimulus(8'h01, 1'b1);
    checkOutput("drop release gnt", {24'd0, gnt}, 32'h01);
    tick();
    checkOutput("drop release out", out, 32'h00000B00);
    applyStimulus(8'h00, 1'b1);
    tick();
    checkOutput("drop drained", {31'd0, out_valid}, 32'd0);

    // Async reset mid-cycle with a pending word
    d3 = 32'h12345678;
    applyStimulus(8'h08, 1'b1);
    tick();
    checkOutput("areset preload out", out, 32'h12345678);
    applyStimulus(8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("areset out", out, 32'h0);
    checkOutput("areset out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(8'hFF, 1'b1);
    checkOutput("post-reset gnt", {24'd0, gnt}, 32'h01);
    tick();
    checkOutput("post-reset out", out, 32'h00000B00);
    checkOutput("post-reset out_valid", {31'd0, out_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_wb_arbiter8.md
# alu_wb_arbiter8

Round-robin arbiter that shares the ALU's 8:1 32-bit result mux among eight requesters. It picks one requesting source per cycle, drives the 3-bit mux select, and registers the selected 32-bit word into a single-entry output stage. That stage uses a valid/ready handshake toward the writeback stage. It sits between the functional units (shifter, adder, logic, multiplier, and so on) and the register-file write port, and instantiates the existing 8:1 32-bit mux for the data path.

## Interface
- RESET_PTR, 3'd7, value loaded into the round-robin pointer on reset; 7 gives requester 0 first priority.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- req  input  8  per-requester request; bit i maps to mux select value i (bit 0 = sel 000 … bit 7 = sel 111).
- d0 … d7  input  32 each  requester data; must be held stable while the matching req bit is high and ungranted.
- gnt  output  8  one-hot grant, combinational; gnt[i]=1 means d[i] is captured at this rising edge.
- sel  output  3  combinational select for the 8:1 mux; equals the winning index; 0 when no request.
- out  output  32  registered result word.
- out_valid  output  1  out holds an undelivered word.
- out_ready  input  1  consumer accepts out when out_valid & out_ready at a rising edge.

## Operation
- State:
  - ptr[2:0]: index of the last granted requester.
  - out[31:0] and out_valid: the output stage.
- Load enable: load_en = !out_valid | out_ready.
- Arbitration, combinational every cycle:
  - Scan indices ptr+1, ptr+2, … ptr+8, each taken mod 8.
  - The winner is the first index whose req bit is 1.
  - sel = winner, or 0 when req == 0.
- gnt[winner] = load_en & (req != 0). All other gnt bits are 0. gnt is never asserted when req == 0.
- On a rising edge with a grant:
  - out <= mux(sel), i.e. d[winner].
  - out_valid <= 1.
  - ptr <= winner.
- On a rising edge with no grant and out_valid & out_ready: out_valid <= 0. out keeps its old value and is don't-care when invalid.
- On a rising edge with no grant and out_valid & !out_ready: everything holds (stall).
- Requester protocol:
  - A transfer is req[i] & gnt[i] at a clock edge.
  - After a transfer the requester either deasserts req[i] or presents its next word.
  - A requester may drop req[i] without a grant. It simply leaves arbitration, and no data is lost by the arbiter.
- Fairness: with all eight requesting continuously and out_ready = 1, grants cycle 0,1,…,7,0 after reset. Any requester waits at most 7 grants.
- ptr changes only on a grant. Stall cycles do not rotate priority.

## Timing
- Reset values, applied asynchronously while rst = 1:
  - ptr = RESET_PTR.
  - out = 32'h0, out_valid = 0.
  - gnt = 0 and sel = 0 as long as req == 0. gnt stays combinational from req and state.
- Latency: req[i] high at edge N-1 with the output stage free → gnt[i] during cycle N → out = d_i and out_valid = 1 after edge N.
- Throughput: one word per cycle while out_ready = 1.
- Simultaneous drain and load, when out_valid & out_ready and req != 0:
  - The old word is consumed and the new word is captured on the same edge.
  - out_valid stays 1 and there is no bubble.
- Backpressure: while out_valid & !out_ready, gnt = 0, but sel still tracks the combinational winner. out and out_valid are unchanged.
- Wrap-around: with ptr = 7, index 0 is scanned first.
- Reset mid-operation:
  - A pending out_valid word is discarded.
  - ptr returns to RESET_PTR.
  - The first grant after rst deasserts follows reset priority.
- rst deassertion is assumed synchronous to clk externally. The first state update is on the first rising edge with rst = 0.

## Test plan
- Reset priority: after reset, req = 8'hFF, out_ready = 1, d_i = 32'hA0+i → out sequence 0xA0,0xA1,…,0xA7,0xA0 on consecutive cycles; gnt walks 8'h01,8'h02,…,8'h80,8'h01.
- Single requester: req = 8'h20, d5 = 32'hDEADBEEF → gnt = 8'h20 and sel = 3'd5 in the same cycle; out = 32'hDEADBEEF and out_valid = 1 next cycle.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with req = 8'h0C → gnt = 0 and out/out_valid stable for all 3 cycles; ptr unchanged. On release → gnt = 8'h04 (ptr was 1), then 8'h08.
- Wrap: last grant index 6, req = 8'h81 → grants 7 then 0 (gnt = 8'h80, then 8'h01).
- Drop without grant: req = 8'h03 while stalled, req[1] deasserted before release → only requester 0 granted; no spurious gnt[1] and no data from d1 appears.
- Async reset: assert rst mid-cycle while out_valid = 1 and out = 32'h12345678 → out = 0 and out_valid = 0 immediately, without waiting for clk; next grant with req = 8'hFF goes to requester 0.
